// File: rtl/smem_bank_arbiter_if.sv
// Request/response and bank-side bus for one shared-memory bank arbiter.
// slave: the arbiter; master: the requesting lanes plus the bank itself.
interface smem_bank_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_write;
    logic [12*NREQ-1:0]   req_addr;
    logic [8*NREQ-1:0]    req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [8*NREQ-1:0]    rsp_data;
    logic                 rsp_err;
    logic                 bank_read;
    logic                 bank_write;
    logic [7:0]           bank_addr;
    logic [7:0]           bank_data;
    logic [7:0]           bank_data_out;
    logic                 bank_finish;
    logic                 busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        input  bank_data_out, bank_finish,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output bank_read, bank_write, bank_addr, bank_data, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_data,
        output bank_data_out, bank_finish,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  bank_read, bank_write, bank_addr, bank_data, busy
    );
endinterface

// File: rtl/smem_bank_arbiter.sv
// Per-bank round-robin arbiter: filters lane requests for BANK_ID, issues one
// bank strobe at a time, returns data/completion (or timeout error) to the lane.
// Ports: clock, reset (async, active-low), bus (smem_bank_arbiter_if.slave).
module smem_bank_arbiter #(
    parameter int         NREQ    = 4,
    parameter logic [3:0] BANK_ID = 4'd0,
    parameter int         TIMEOUT = 8
) (
    input logic                clock,
    input logic                reset,
    smem_bank_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gnt_q, gnt_d;
    logic               write_q, write_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [8*NREQ-1:0]  rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]    eligible;
    logic               found;
    logic [IW-1:0]      sel;
    logic [IW:0]        sum;
    logic [IW-1:0]      gnt_next;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = bus.req_valid[i] &&
                          (bus.req_addr[12*i+8 +: 4] == BANK_ID);
        end
    end

    // First eligible lane scanning upward from ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            if (!found && eligible[sum[IW-1:0]]) begin
                found = 1'b1;
                sel   = sum[IW-1:0];
            end
        end
    end

    assign gnt_next = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = sel;
                    write_d = bus.req_write[sel];
                    addr_d  = bus.req_addr[12*sel +: 8];
                    data_d  = bus.req_data[8*sel +: 8];
                    rd_d    = ~bus.req_write[sel];
                    wr_d    = bus.req_write[sel];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.bank_finish) begin
                    if (!write_q) begin
                        rsp_data_d[8*gnt_q +: 8] = bus.bank_data_out;
                    end
                    rsp_valid_d[gnt_q] = 1'b1;
                    ptr_d   = gnt_next;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_err_d = 1'b1;
                    ptr_d     = gnt_next;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Grant is suppressed while reset is held so nothing is offered mid-reset.
    assign bus.req_ready  = (reset && state_q == S_IDLE && found)
                          ? (NREQ'(1) << sel) : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.bank_read  = rd_q;
    assign bus.bank_write = wr_q;
    assign bus.bank_addr  = addr_q;
    assign bus.bank_data  = data_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_smem_bank_arbiter.sv
// Testbench for smem_bank_arbiter: directed scenarios plus randomized traffic
// against a cycle-count reference model and a one-cycle-latency bank model.
module tb_smem_bank_arbiter;
    localparam int         NREQ = 4;
    localparam logic [3:0] BID  = 4'd3;
    localparam int         TMO  = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    smem_bank_arbiter_if #(.NREQ(NREQ)) bus();

    smem_bank_arbiter #(.NREQ(NREQ), .BANK_ID(BID), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [NREQ-1:0] v = '0;
    logic [NREQ-1:0] w = '0;
    logic [11:0]     a [NREQ] = '{default: 12'h000};
    logic [7:0]      d [NREQ] = '{default: 8'h00};

    assign bus.req_valid = v;
    assign bus.req_write = w;
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign bus.req_addr[12*gi +: 12] = a[gi];
        assign bus.req_data[8*gi +: 8]   = d[gi];
    end

    // Bank model: finish and data one cycle after a sampled strobe.
    logic       bank_en = 1'b1;
    logic       bf      = 1'b0;
    logic [7:0] bdo     = 8'h00;
    logic [7:0] bmem [256] = '{default: 8'h00};
    assign bus.bank_finish   = bf;
    assign bus.bank_data_out = bdo;
    always @(posedge clock) begin
        bf  <= bank_en & (bus.bank_read | bus.bank_write);
        bdo <= bmem[bus.bank_addr];
        if (bus.bank_write) bmem[bus.bank_addr] <= bus.bank_data;
    end

    int         total = 0;
    int         bad   = 0;
    int         m_ptr = 0;
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] ref_rsp [NREQ] = '{default: 8'h00};

    function automatic logic [NREQ-1:0] elig_of();
        logic [NREQ-1:0] e;
        for (int i = 0; i < NREQ; i++) e[i] = v[i] && (a[i][11:8] == BID);
        return e;
    endfunction

    function automatic int scan(logic [NREQ-1:0] el, int p);
        for (int k = 0; k < NREQ; k++) begin
            if (el[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [8*NREQ-1:0] pack_rsp();
        logic [8*NREQ-1:0] r;
        for (int i = 0; i < NREQ; i++) r[8*i +: 8] = ref_rsp[i];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        v = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) ref_rsp[i] = 8'h00;
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] er;
        @(negedge clock);
        v[0] = 1'b1;
        a[0] = 12'h300;
        #1;
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.bank_read,
             bus.bank_write, bus.bank_addr, bus.bank_data, bus.busy} !== '0) begin
            bad++;
            $display("FAIL reset_outs: ready=%b rv=%b err=%b rd=%b wr=%b ba=%h bd=%h busy=%b want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.bank_read,
                     bus.bank_write, bus.bank_addr, bus.bank_data, bus.busy);
        end
        total++;
        if (bus.rsp_data !== '0) begin
            bad++;
            $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data);
        end
        v[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_ptr = 0;
        #1;
        er = '0;
        total++;
        if ({bus.busy, bus.req_ready} !== {1'b0, er}) begin
            bad++;
            $display("FAIL reset_release: busy=%b ready=%b want 0/0", bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_write_read();
        int wcnt;
        int e;
        @(negedge clock);
        v[1] = 1'b1; w[1] = 1'b1; a[1] = 12'h305; d[1] = 8'hA5;
        #1;
        e = scan(elig_of(), m_ptr);
        total++;
        if (bus.req_ready !== 4'(1 << e)) begin
            bad++;
            $display("FAIL wr_grant: got %b want %b", bus.req_ready, 4'(1 << e));
        end
        @(negedge clock);
        v[1] = 1'b0;
        ref_mem[8'h05] = 8'hA5;
        m_ptr = (e + 1) % NREQ;
        wcnt = int'(bus.bank_write);
        total++;
        if ({bus.bank_write, bus.bank_read, bus.bank_addr, bus.bank_data} !==
            {1'b1, 1'b0, 8'h05, 8'hA5}) begin
            bad++;
            $display("FAIL wr_strobe: wr=%b rd=%b a=%h d=%h want 1 0 05 a5",
                     bus.bank_write, bus.bank_read, bus.bank_addr, bus.bank_data);
        end
        @(negedge clock);
        wcnt += int'(bus.bank_write);
        @(negedge clock);
        wcnt += int'(bus.bank_write);
        total++;
        if ({bus.rsp_valid, bus.rsp_err} !== {4'b0010, 1'b0}) begin
            bad++;
            $display("FAIL wr_rsp: rv=%b err=%b want 0010 0", bus.rsp_valid, bus.rsp_err);
        end
        v[1] = 1'b1; w[1] = 1'b0;
        #1;
        e = scan(elig_of(), m_ptr);
        total++;
        if (bus.req_ready !== 4'(1 << e)) begin
            bad++;
            $display("FAIL rd_grant: got %b want %b", bus.req_ready, 4'(1 << e));
        end
        @(negedge clock);
        v[1] = 1'b0;
        m_ptr = (e + 1) % NREQ;
        wcnt += int'(bus.bank_write);
        total++;
        if (bus.bank_read !== 1'b1) begin
            bad++;
            $display("FAIL rd_strobe: got %b want 1", bus.bank_read);
        end
        @(negedge clock);
        wcnt += int'(bus.bank_write);
        @(negedge clock);
        ref_rsp[1] = ref_mem[8'h05];
        total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data[15:8]} !==
            {4'b0010, 1'b0, ref_rsp[1]}) begin
            bad++;
            $display("FAIL rd_rsp: rv=%b err=%b data=%h want 0010 0 %h",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data[15:8], ref_rsp[1]);
        end
        total++;
        if (wcnt !== 1) begin
            bad++;
            $display("FAIL wr_once: bank_write cycles=%0d want 1", wcnt);
        end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        @(negedge clock);
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1; w[i] = 1'b1;
            a[i] = {BID, 8'(8'h40 + i)};
            d[i] = 8'(8'h10 + i);
        end
        for (int g = 0; g < NREQ; g++) begin
            #1;
            e = scan(elig_of(), m_ptr);
            total++;
            if (bus.req_ready !== 4'(1 << e)) begin
                bad++;
                $display("FAIL rr_grant%0d: got %b want %b", g, bus.req_ready, 4'(1 << e));
            end
            @(negedge clock);
            v[e] = 1'b0;
            ref_mem[a[e][7:0]] = d[e];
            m_ptr = (e + 1) % NREQ;
            total++;
            if ({bus.bank_write, bus.bank_data} !== {1'b1, 8'(8'h10 + g)}) begin
                bad++;
                $display("FAIL rr_data%0d: wr=%b d=%h want 1 %h", g,
                         bus.bank_write, bus.bank_data, 8'(8'h10 + g));
            end
            @(negedge clock);
            @(negedge clock);
            total++;
            if (bus.rsp_valid !== 4'(1 << e)) begin
                bad++;
                $display("FAIL rr_rsp%0d: got %b want %b", g, bus.rsp_valid, 4'(1 << e));
            end
        end
        v = '1;
        #1;
        e = scan(elig_of(), m_ptr);
        total++;
        if (bus.req_ready !== 4'(1 << e)) begin
            bad++;
            $display("FAIL rr_ptr_wrap: got %b want %b", bus.req_ready, 4'(1 << e));
        end
        v = '0;
        @(negedge clock);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_withdraw: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_alternate();
        int   e;
        logic prev0;
        prev0 = 1'b0;
        @(negedge clock);
        for (int i = 0; i < NREQ; i += 2) begin
            v[i] = 1'b1; w[i] = 1'b1;
            a[i] = {BID, 8'(8'h20 + i)};
            d[i] = 8'($urandom);
        end
        for (int g = 0; g < 6; g++) begin
            #1;
            e = scan(elig_of(), m_ptr);
            total++;
            if (bus.req_ready !== 4'(1 << e)) begin
                bad++;
                $display("FAIL alt_grant%0d: got %b want %b", g, bus.req_ready, 4'(1 << e));
            end
            total++;
            if (prev0 && bus.req_ready[0] === 1'b1) begin
                bad++;
                $display("FAIL alt_lane0_twice%0d: ready=%b", g, bus.req_ready);
            end
            prev0 = bus.req_ready[0];
            @(negedge clock);
            ref_mem[a[e][7:0]] = d[e];
            m_ptr = (e + 1) % NREQ;
            total++;
            if ({bus.bank_write, bus.bank_data} !== {1'b1, d[e]}) begin
                bad++;
                $display("FAIL alt_data%0d: wr=%b d=%h want 1 %h", g,
                         bus.bank_write, bus.bank_data, d[e]);
            end
            d[e] = 8'($urandom);
            @(negedge clock);
            @(negedge clock);
            total++;
            if (bus.rsp_valid !== 4'(1 << e)) begin
                bad++;
                $display("FAIL alt_rsp%0d: got %b want %b", g, bus.rsp_valid, 4'(1 << e));
            end
        end
        v = '0;
    endtask

    task automatic test_other_bank();
        @(negedge clock);
        v[0] = 1'b1; w[0] = 1'b0; a[0] = 12'h1FF;
        for (int c = 0; c < 20; c++) begin
            #1;
            total++;
            if ({bus.req_ready, bus.bank_read, bus.bank_write, bus.busy} !== '0) begin
                bad++;
                $display("FAIL other_bank%0d: ready=%b rd=%b wr=%b busy=%b want 0",
                         c, bus.req_ready, bus.bank_read, bus.bank_write, bus.busy);
            end
            @(negedge clock);
        end
        v[0] = 1'b0;
    endtask

    task automatic test_timeout();
        int         e;
        logic [3:0] erv;
        bank_en = 1'b0;
        @(negedge clock);
        v[2] = 1'b1; w[2] = 1'b0; a[2] = {BID, 8'h05};
        #1;
        e = scan(elig_of(), m_ptr);
        total++;
        if (bus.req_ready !== 4'(1 << e)) begin
            bad++;
            $display("FAIL to_grant: got %b want %b", bus.req_ready, 4'(1 << e));
        end
        @(negedge clock);
        v[2] = 1'b0;
        m_ptr = (e + 1) % NREQ;
        for (int i = 2; i <= TMO + 4; i++) begin
            @(negedge clock);
            erv = (i == TMO + 2) ? 4'(1 << e) : 4'b0000;
            total++;
            if ({bus.rsp_valid, bus.rsp_err, bus.busy} !==
                {erv, (i == TMO + 2), (i < TMO + 2)}) begin
                bad++;
                $display("FAIL to_cycle%0d: rv=%b err=%b busy=%b want %b %b %b", i,
                         bus.rsp_valid, bus.rsp_err, bus.busy, erv,
                         (i == TMO + 2), (i < TMO + 2));
            end
            if (i == TMO + 2) begin
                total++;
                if (bus.rsp_data !== pack_rsp()) begin
                    bad++;
                    $display("FAIL to_data_held: got %h want %h", bus.rsp_data, pack_rsp());
                end
            end
        end
        bank_en = 1'b1;
        v[3] = 1'b1; w[3] = 1'b1; a[3] = {BID, 8'h77}; d[3] = 8'h5A;
        #1;
        e = scan(elig_of(), m_ptr);
        total++;
        if (bus.req_ready !== 4'(1 << e)) begin
            bad++;
            $display("FAIL to_next_grant: got %b want %b", bus.req_ready, 4'(1 << e));
        end
        @(negedge clock);
        v[3] = 1'b0;
        ref_mem[8'h77] = 8'h5A;
        m_ptr = (e + 1) % NREQ;
        @(negedge clock);
        @(negedge clock);
        total++;
        if ({bus.rsp_valid, bus.rsp_err} !== {4'(1 << e), 1'b0}) begin
            bad++;
            $display("FAIL to_next_rsp: rv=%b err=%b want %b 0", bus.rsp_valid,
                     bus.rsp_err, 4'(1 << e));
        end
    endtask

    task automatic test_reset_wait();
        int e;
        @(negedge clock);
        v[1] = 1'b1; w[1] = 1'b0; a[1] = {BID, 8'h05};
        #1;
        e = scan(elig_of(), m_ptr);
        total++;
        if (bus.req_ready !== 4'(1 << e)) begin
            bad++;
            $display("FAIL rw_grant: got %b want %b", bus.req_ready, 4'(1 << e));
        end
        @(negedge clock);
        v[1] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.bank_read, bus.bank_write,
             bus.bank_addr, bus.bank_data, bus.busy, bus.rsp_data} !== '0) begin
            bad++;
            $display("FAIL rw_outs_zero: ready=%b rv=%b busy=%b ba=%h rd=%h want all 0",
                     bus.req_ready, bus.rsp_valid, bus.busy, bus.bank_addr, bus.rsp_data);
        end
        for (int i = 0; i < NREQ; i++) ref_rsp[i] = 8'h00;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        m_ptr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            total++;
            if ({bus.rsp_valid, bus.busy} !== 5'b0) begin
                bad++;
                $display("FAIL rw_no_rsp%0d: rv=%b busy=%b want 0 0", c, bus.rsp_valid, bus.busy);
            end
        end
        v[1] = 1'b1; v[3] = 1'b1; w[3] = 1'b0; a[3] = {BID, 8'h77};
        #1;
        e = scan(elig_of(), m_ptr);
        total++;
        if (bus.req_ready !== 4'(1 << e)) begin
            bad++;
            $display("FAIL rw_first_grant: got %b want %b", bus.req_ready, 4'(1 << e));
        end
        @(negedge clock);
        v[e] = 1'b0;
        m_ptr = (e + 1) % NREQ;
        ref_rsp[e] = ref_mem[a[e][7:0]];
        @(negedge clock);
        @(negedge clock);
        v = '0;
        total++;
        if ({bus.rsp_valid, bus.rsp_data} !== {4'(1 << e), pack_rsp()}) begin
            bad++;
            $display("FAIL rw_after_rsp: rv=%b data=%h want %b %h", bus.rsp_valid,
                     bus.rsp_data, 4'(1 << e), pack_rsp());
        end
    endtask

    task automatic test_random();
        int         free_at, rsp_at, rsp_lane, st_at, acc;
        int         e;
        logic       rsp_w, st_w;
        logic [7:0] st_a, st_d, rsp_val;
        logic [3:0] erv, err_exp;
        free_at = 0; rsp_at = -1; rsp_lane = 0; st_at = -1; acc = -1;
        rsp_w = 1'b0; st_w = 1'b0; st_a = 8'h00; st_d = 8'h00; rsp_val = 8'h00;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            erv = (n == rsp_at) ? 4'(1 << rsp_lane) : 4'b0000;
            if (n == rsp_at && !rsp_w) ref_rsp[rsp_lane] = rsp_val;
            total++;
            if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {erv, 1'b0, pack_rsp()}) begin
                bad++;
                $display("FAIL rnd_rsp@%0d: rv=%b err=%b data=%h want %b 0 %h", n,
                         bus.rsp_valid, bus.rsp_err, bus.rsp_data, erv, pack_rsp());
            end
            total++;
            if (n == st_at) begin
                if ({bus.bank_read, bus.bank_write, bus.bank_addr, bus.bank_data} !==
                    {~st_w, st_w, st_a, st_d}) begin
                    bad++;
                    $display("FAIL rnd_strobe@%0d: rd=%b wr=%b a=%h d=%h want %b %b %h %h", n,
                             bus.bank_read, bus.bank_write, bus.bank_addr, bus.bank_data,
                             ~st_w, st_w, st_a, st_d);
                end
            end else if ({bus.bank_read, bus.bank_write} !== 2'b00) begin
                bad++;
                $display("FAIL rnd_idle_strobe@%0d: rd=%b wr=%b want 0 0", n,
                         bus.bank_read, bus.bank_write);
            end
            if (acc >= 0) v[acc] = 1'b0;
            acc = -1;
            err_exp = elig_of();
            for (int i = 0; i < NREQ; i++) begin
                if (v[i] && !err_exp[i] && $urandom_range(0, 3) == 0) begin
                    v[i] = 1'b0;
                end else if (!v[i] && $urandom_range(0, 3) == 0) begin
                    v[i] = 1'b1;
                    w[i] = 1'($urandom_range(0, 1));
                    a[i] = {($urandom_range(0, 4) == 0) ? 4'h5 : BID,
                            8'($urandom_range(0, 7))};
                    d[i] = 8'($urandom);
                end
            end
            #1;
            e = (n >= free_at) ? scan(elig_of(), m_ptr) : -1;
            erv = (e >= 0) ? 4'(1 << e) : 4'b0000;
            total++;
            if (bus.req_ready !== erv) begin
                bad++;
                $display("FAIL rnd_ready@%0d: got %b want %b", n, bus.req_ready, erv);
            end
            if (e >= 0) begin
                acc = e; free_at = n + 3; st_at = n + 1; rsp_at = n + 3; rsp_lane = e;
                st_w = w[e]; st_a = a[e][7:0]; st_d = d[e]; rsp_w = w[e];
                if (w[e]) ref_mem[a[e][7:0]] = d[e];
                else rsp_val = ref_mem[a[e][7:0]];
                m_ptr = (e + 1) % NREQ;
            end
        end
        v = '0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_alternate();
        test_other_bank();
        test_timeout();
        test_reset_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
